nbit_1x4_dispatch: RTL and testbench

NBIT_1X4_DISPATCH -- requirements
Module: nbit_1x4_dispatch

---
 rtl/nbit_1x4_dispatch.sv | 86 ++++++++
 tb/tb_nbit_1x4_dispatch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/nbit_1x4_dispatch.sv
// One-to-four dispatcher: each output owns a single-entry register slot loaded by in_sel.
// Optional per-slot delivered-word counters are built when DISPATCH_COUNT_EN is defined.
module nbit_1x4_dispatch #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   in_sel,
   input  logic [N-1:0] in_data,
   output logic [3:0]   out_valid,
   input  logic [3:0]   out_ready,
   output logic [N-1:0] out_data0,
   output logic [N-1:0] out_data1,
   output logic [N-1:0] out_data2,
   output logic [N-1:0] out_data3
`ifdef DISPATCH_COUNT_EN
   ,
   output logic [63:0]  out_count
`endif
);

   // Handshake: a word moves on any cycle where valid && ready are both high at the
   // rising edge; valid never waits on ready, and ready may depend on the sink side.
   logic [3:0]   full;
   logic [N-1:0] slot_data [4];
   logic         accept;
   logic [3:0]   load;
   logic [3:0]   drain;

   // A slot can accept when empty or when it is being emptied this same cycle.
   always_comb begin
      in_ready = rst_n && (!full[in_sel] || out_ready[in_sel]) && !flush;
      accept   = in_valid && in_ready;
      load     = 4'b0000;
      if (accept) load[in_sel] = 1'b1;
      drain    = full & out_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 4'b0000;
      end else if (flush) begin
         full <= 4'b0000;
      end else begin
         full <= load | (full & ~drain);
      end
   end

   // Payload registers are only written on load, so they hold across drain and flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) slot_data[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (load[k]) slot_data[k] <= in_data;
         end
      end
   end

   assign out_valid = full;
   assign out_data0 = slot_data[0];
   assign out_data1 = slot_data[1];
   assign out_data2 = slot_data[2];
   assign out_data3 = slot_data[3];

`ifdef DISPATCH_COUNT_EN
   logic [15:0] cnt [4];

   // Drains during flush still deliver a word, so flush does not gate counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (drain[k]) cnt[k] <= cnt[k] + 16'd1;
         end
      end
   end

   assign out_count = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_nbit_1x4_dispatch.sv
// Directed bench for nbit_1x4_dispatch; counter checks are built when DISPATCH_COUNT_EN is defined.
module tb_nbit_1x4_dispatch;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_sel;
   logic [N-1:0] in_data;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;
   logic [N-1:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DISPATCH_COUNT_EN
   logic [63:0]  out_count;
`endif

   int checks = 0;
   int errors = 0;

   nbit_1x4_dispatch #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3)
`ifdef DISPATCH_COUNT_EN
      ,
      .out_count (out_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs are then changed 1ns after it, away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [N-1:0] d, input logic [3:0] r);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
      #1;
      check("reset_out_valid", 64'(out_valid), 64'h0);
      check("reset_in_ready", 64'(in_ready), 64'h0);
      check("reset_data0", 64'(out_data0), 64'h0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      check("release_in_ready", 64'(in_ready), 64'h1);

      // Basic route to slot 2, then a second word is refused
      drive(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
      check("route_in_ready", 64'(in_ready), 64'h1);
      tick();
      drive(1'b1, 2'd2, 32'h12345678, 4'b0000);
      check("route_out_valid", 64'(out_valid), 64'h4);
      check("route_data2", 64'(out_data2), 64'hDEADBEEF);
      check("route_blocked", 64'(in_ready), 64'h0);
      tick();
      drive(1'b0, 2'd2, 32'h0, 4'b0100);
      check("no_overwrite", 64'(out_data2), 64'hDEADBEEF);
      tick();
      drive(1'b0, 2'd0, 32'h0, 4'b0000);
      check("drain2_valid", 64'(out_valid), 64'h0);
      check("drain2_retain", 64'(out_data2), 64'hDEADBEEF);

      // Streaming one word per cycle through slot 1
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 2'd1, N'(i), 4'b0010);
         check($sformatf("stream_ready_%0d", i), 64'(in_ready), 64'h1);
         tick();
         check($sformatf("stream_data_%0d", i), 64'(out_data1), 64'(i));
         check($sformatf("stream_valid_%0d", i), 64'(out_valid), 64'h2);
      end
      drive(1'b0, 2'd1, 32'h0, 4'b0010);
      tick();
      check("stream_empty", 64'(out_valid), 64'h0);

      // Independence: slot 0 stalled does not block slot 3
      drive(1'b1, 2'd0, 32'hA0, 4'b0000);
      tick();
      drive(1'b1, 2'd3, 32'h33, 4'b0000);
      check("indep_ready3", 64'(in_ready), 64'h1);
      tick();
      drive(1'b1, 2'd0, 32'h55, 4'b0000);
      check("indep_valid", 64'(out_valid), 64'h9);
      check("indep_data3", 64'(out_data3), 64'h33);
      check("indep_block0", 64'(in_ready), 64'h0);
      tick();
      drive(1'b1, 2'd0, 32'h55, 4'b0001);
      check("indep_hold0", 64'(out_data0), 64'hA0);
      check("indep_ready0", 64'(in_ready), 64'h1);
      tick();
      drive(1'b1, 2'd1, 32'h11, 4'b0000);
      check("swap_data0", 64'(out_data0), 64'h55);
      check("swap_valid", 64'(out_valid), 64'h9);
      tick();
      drive(1'b1, 2'd2, 32'h22, 4'b0000);
      tick();

      // Flush with all four full and a pending word
      drive(1'b1, 2'd1, 32'h99, 4'b0000);
      flush = 1'b1;
      #1;
      check("full_valid", 64'(out_valid), 64'hF);
      check("flush_in_ready", 64'(in_ready), 64'h0);
      tick();
      flush = 1'b0;
      drive(1'b0, 2'd0, 32'h0, 4'b0000);
      check("flush_valid", 64'(out_valid), 64'h0);
      check("flush_data", {out_data3[15:0], out_data2[15:0], out_data1[15:0], out_data0[15:0]},
            64'h0033_0022_0011_0055);

      // Reset asserted with slots full, then immediate use after release
      drive(1'b1, 2'd0, 32'h66, 4'b0000);
      tick();
      drive(1'b1, 2'd1, 32'h67, 4'b0000);
      tick();
      drive(1'b0, 2'd0, 32'h0, 4'b0000);
      check("pre_reset_valid", 64'(out_valid), 64'h3);
      rst_n = 1'b0;
      #1;
      check("mid_reset_valid", 64'(out_valid), 64'h0);
      check("mid_reset_ready", 64'(in_ready), 64'h0);
      check("mid_reset_data", {out_data3[15:0], out_data2[15:0], out_data1[15:0], out_data0[15:0]},
            64'h0);
      rst_n = 1'b1;
      drive(1'b1, 2'd0, 32'h77, 4'b0000);
      check("post_reset_ready", 64'(in_ready), 64'h1);
      tick();
      drive(1'b0, 2'd0, 32'h0, 4'b0000);
      check("post_reset_valid", 64'(out_valid), 64'h1);
      check("post_reset_data0", 64'(out_data0), 64'h77);

`ifdef DISPATCH_COUNT_EN
      rst_n = 1'b0;
      #1;
      check("count_reset", out_count, 64'h0);
      rst_n = 1'b1;
      // 65537 loads through slot 0, each drained once, wraps counter 0 to 1
      drive(1'b1, 2'd0, 32'h1, 4'b0001);
      for (int i = 0; i < 65537; i++) tick();
      drive(1'b0, 2'd0, 32'h0, 4'b0001);
      tick();
      check("count_wrap", out_count, 64'h0000_0000_0000_0001);
      // Drain during flush still counts
      drive(1'b1, 2'd2, 32'h5, 4'b0000);
      tick();
      drive(1'b0, 2'd0, 32'h0, 4'b0100);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("count_flush_drain", out_count, 64'h0000_0001_0000_0001);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
